// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage RV32 pipeline.
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs1,
    input  logic             ifid_uses_rs2,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             mem_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_write,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [3:0]       init_cnt_q, init_cnt_d;
    logic             branch_pending_q, branch_pending_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             load_use, br, stall_inc, flush_inc;

    assign load_use = idex_mem_read && idex_rd != 5'd0 &&
                      ((ifid_uses_rs1 && idex_rd == ifid_rs1) || (ifid_uses_rs2 && idex_rd == ifid_rs2));
    assign br = mem_branch_taken || branch_pending_q;

    always_comb begin
        state_d          = state_q;
        init_cnt_d       = init_cnt_q;
        branch_pending_d = branch_pending_q;
        pc_write         = 1'b1;
        ifid_write       = 1'b1;
        ifid_flush       = 1'b0;
        idex_flush       = 1'b0;
        exmem_flush      = 1'b0;
        pipe_write       = 1'b1;
        flush_inc        = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                state_d = RUN;
                if (dmem_busy) begin
                    // Freeze; a branch seen while entering the wait is remembered for the exit cycle
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_write = 1'b0;
                    state_d    = MEM_WAIT;
                    if (state_q == RUN && mem_branch_taken) branch_pending_d = 1'b1;
                end else if (br) begin
                    ifid_flush       = 1'b1;
                    idex_flush       = 1'b1;
                    exmem_flush      = 1'b1;
                    flush_inc        = 1'b1;
                    branch_pending_d = 1'b0;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            default: begin
                pc_write    = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                init_cnt_d  = init_cnt_q - 4'd1;
                state_d     = init_cnt_q == 4'd0 ? RUN : INIT;
            end
        endcase
        stall_inc = state_q != INIT && !pc_write;
        stall_d   = stall_q + {{(CNT_W-1){1'b0}}, stall_inc && !(&stall_q)};
        flush_d   = flush_q + {{(CNT_W-1){1'b0}}, flush_inc && !(&flush_q)};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= INIT;
            init_cnt_q       <= 4'(INIT_CYCLES - 1);
            branch_pending_q <= 1'b0;
            stall_q          <= '0;
            flush_q          <= '0;
        end else begin
            state_q          <= state_d;
            init_cnt_q       <= init_cnt_d;
            branch_pending_q <= branch_pending_d;
            stall_q          <= stall_d;
            flush_q          <= flush_d;
        end
    end

    assign ctrl_state   = state_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
    localparam int INIT_CYCLES = 4;

    logic        clock = 1'b0;
    logic        reset, ifid_uses_rs1, ifid_uses_rs2, idex_mem_read, mem_branch_taken, dmem_busy;
    logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_write;
    logic        pc_write2, ifid_write2, ifid_flush2, idex_flush2, exmem_flush2, pipe_write2;
    logic [1:0]  ctrl_state, ctrl_state2;
    logic [15:0] stall_cycles, flush_events;
    logic [1:0]  stall_cycles2, flush_events2;

    int checks = 0;
    int errors = 0;

    int      m_mode;
    int      m_left;
    bit      m_pend;
    longint  m_stall, m_flush;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .mem_branch_taken(mem_branch_taken), .dmem_busy(dmem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pipe_write(pipe_write),
        .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    // Narrow-counter copy exercises saturation
    pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .mem_branch_taken(mem_branch_taken), .dmem_busy(dmem_busy),
        .pc_write(pc_write2), .ifid_write(ifid_write2), .ifid_flush(ifid_flush2),
        .idex_flush(idex_flush2), .exmem_flush(exmem_flush2), .pipe_write(pipe_write2),
        .ctrl_state(ctrl_state2), .stall_cycles(stall_cycles2), .flush_events(flush_events2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint lim = (longint'(1) << w) - 1;
        return v > lim ? lim : v;
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_write}
    function automatic logic [5:0] expect_ctrl();
        bit lu = idex_mem_read && idex_rd != 0 &&
                 ((ifid_uses_rs1 && idex_rd == ifid_rs1) || (ifid_uses_rs2 && idex_rd == ifid_rs2));
        if (m_mode == 0) return 6'b011111;
        if (dmem_busy) return 6'b000000;
        if (mem_branch_taken || m_pend) return 6'b111111;
        if (lu) return 6'b000101;
        return 6'b110001;
    endfunction

    task automatic cycle(input bit r, input bit bz, input bit bt, input bit mr, input int rd,
                         input int rs1, input int rs2, input bit u1, input bit u2);
        logic [5:0] e;
        @(negedge clock);
        reset = r; dmem_busy = bz; mem_branch_taken = bt; idex_mem_read = mr;
        idex_rd = 5'(rd); ifid_rs1 = 5'(rs1); ifid_rs2 = 5'(rs2);
        ifid_uses_rs1 = u1; ifid_uses_rs2 = u2;
        #1;
        e = expect_ctrl();
        check("ctrl", 32'({pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_write}), 32'(e));
        check("state", 32'(ctrl_state), 32'(m_mode));
        check("stall", 32'(stall_cycles), 32'(sat(m_stall, 16)));
        check("flush", 32'(flush_events), 32'(sat(m_flush, 16)));
        check("stall_sat", 32'(stall_cycles2), 32'(sat(m_stall, 2)));
        check("flush_sat", 32'(flush_events2), 32'(sat(m_flush, 2)));
        if (m_mode != 0 && !e[5]) m_stall++;
        if (r) begin
            m_mode = 0; m_left = INIT_CYCLES; m_pend = 0; m_stall = 0; m_flush = 0;
        end else if (m_mode == 0) begin
            m_left--;
            if (m_left == 0) m_mode = 1;
        end else if (bz) begin
            if (m_mode == 1 && bt) m_pend = 1;
            m_mode = 2;
        end else begin
            if (bt || m_pend) m_flush++;
            if (bt || m_pend) m_pend = 0;
            m_mode = 1;
        end
        if (r) m_stall = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_mode = 1; m_left = 0; m_pend = 0; m_stall = 0; m_flush = 0;
        reset = 1'b1;
        // First reset cycle: DUT state unknown, so drive it without checking
        @(negedge clock);
        {dmem_busy, mem_branch_taken, idex_mem_read, ifid_uses_rs1, ifid_uses_rs2} = '0;
        {idex_rd, ifid_rs1, ifid_rs2} = '0;
        m_mode = 0; m_left = INIT_CYCLES;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < INIT_CYCLES; i++) cycle(0, 1, 1, 1, 5, 5, 5, 1, 1);
        idle(1);
        check("init_done_state", 32'(ctrl_state), 32'd1);
        cycle(0, 0, 0, 1, 5, 0, 5, 0, 1);
        idle(1);
        check("load_use_stall", 32'(stall_cycles), 32'd1);
        cycle(0, 0, 0, 1, 0, 0, 0, 1, 1);
        cycle(0, 0, 1, 1, 5, 0, 5, 0, 1);
        idle(1);
        check("branch_flush", 32'(flush_events), 32'd1);
        check("branch_no_stall", 32'(stall_cycles), 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("busy_stall", 32'(stall_cycles), 32'd4);
        cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        check("pending_flush", 32'(flush_events), 32'd2);
        cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(INIT_CYCLES + 2);
        check("reset_clears_pending", 32'(flush_events), 32'd0);
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(99) < 2, $urandom_range(99) < 25, $urandom_range(99) < 15,
                  $urandom_range(1), $urandom_range(3), $urandom_range(3), $urandom_range(3),
                  $urandom_range(1), $urandom_range(1));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
